// File: rtl/lagarto_plic_pkg.sv
// Shared definitions for the per-target PLIC core: configuration select
// encodings, default sizing and the priority/ID field types.
package lagarto_plic_pkg;

  localparam int DEFAULT_NUM_SOURCES    = 32;
  localparam int DEFAULT_PRIORITY_WIDTH = 3;
  localparam int DEFAULT_ID_WIDTH       = $clog2(DEFAULT_NUM_SOURCES);

  // Configuration register select; the reserved code drops the write.
  typedef enum logic [1:0] {
    CFG_PRIORITY  = 2'd0,
    CFG_ENABLE    = 2'd1,
    CFG_THRESHOLD = 2'd2,
    CFG_RESERVED  = 2'd3
  } cfg_sel_e;

  typedef logic [DEFAULT_PRIORITY_WIDTH-1:0] priority_t;
  typedef logic [DEFAULT_ID_WIDTH-1:0]       id_t;

endpackage

// File: rtl/lagarto_plic_target_arbiter_if.sv
// Gateway, configuration and hart claim/complete signals of one PLIC target.
// The core uses the slave modport; the hart/gateway side uses master.
interface lagarto_plic_target_arbiter_if
  import lagarto_plic_pkg::*;
#(
  parameter int NUM_SOURCES    = DEFAULT_NUM_SOURCES,
  parameter int PRIORITY_WIDTH = DEFAULT_PRIORITY_WIDTH,
  parameter int ID_WIDTH       = $clog2(NUM_SOURCES)
);
  logic [NUM_SOURCES-1:0]    interrupt_request_i;
  logic [NUM_SOURCES-1:0]    interrupt_claim_complete_o;
  logic                      cfg_we_i;
  logic [1:0]                cfg_sel_i;
  logic [ID_WIDTH-1:0]       cfg_index_i;
  logic [PRIORITY_WIDTH-1:0] cfg_wdata_i;
  logic                      claim_req_i;
  logic                      claim_valid_o;
  logic [ID_WIDTH-1:0]       claim_id_o;
  logic                      complete_req_i;
  logic [ID_WIDTH-1:0]       complete_id_i;
  logic                      eip_o;

  modport slave (
    input  interrupt_request_i, cfg_we_i, cfg_sel_i, cfg_index_i, cfg_wdata_i,
           claim_req_i, complete_req_i, complete_id_i,
    output interrupt_claim_complete_o, claim_valid_o, claim_id_o, eip_o
  );

  modport master (
    output interrupt_request_i, cfg_we_i, cfg_sel_i, cfg_index_i, cfg_wdata_i,
           claim_req_i, complete_req_i, complete_id_i,
    input  interrupt_claim_complete_o, claim_valid_o, claim_id_o, eip_o
  );
endinterface

// File: rtl/lagarto_plic_max_tree.sv
// Combinational log-depth maximum finder over the eligible sources. Each
// node keeps the higher priority; on equal priority the left (lower ID)
// child wins, so the root yields the lowest ID among the highest priority.
module lagarto_plic_max_tree
  import lagarto_plic_pkg::*;
#(
  parameter int NUM_SOURCES    = DEFAULT_NUM_SOURCES,
  parameter int PRIORITY_WIDTH = DEFAULT_PRIORITY_WIDTH,
  parameter int ID_WIDTH       = $clog2(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0]                     eligible_i,
  input  logic [NUM_SOURCES-1:0][PRIORITY_WIDTH-1:0] priority_i,
  output logic [ID_WIDTH-1:0]                        best_id_o,
  output logic [PRIORITY_WIDTH-1:0]                  best_priority_o
);
  localparam int LEAVES = 1 << ID_WIDTH;

  logic [LEAVES-1:0]         node_valid_s;
  logic [PRIORITY_WIDTH-1:0] node_prio_s [LEAVES];
  logic [ID_WIDTH-1:0]       node_id_s   [LEAVES];
  logic                      take_right_s;

  // Reduce the padded leaf row level by level; node n of a level is built
  // from nodes 2n/2n+1 of the previous one, overwriting in place.
  always_comb begin
    take_right_s = 1'b0;
    node_valid_s = '0;
    for (int i = 0; i < LEAVES; i++) begin
      node_prio_s[i] = '0;
      node_id_s[i]   = ID_WIDTH'(i);
    end
    for (int i = 0; i < NUM_SOURCES; i++) begin
      node_valid_s[i] = eligible_i[i];
      node_prio_s[i]  = priority_i[i];
    end
    for (int l = 0; l < ID_WIDTH; l++) begin
      for (int n = 0; n < (LEAVES >> (l + 1)); n++) begin
        take_right_s = node_valid_s[2*n+1] &&
                       (!node_valid_s[2*n] || (node_prio_s[2*n+1] > node_prio_s[2*n]));
        if (take_right_s) begin
          node_valid_s[n] = 1'b1;
          node_prio_s[n]  = node_prio_s[2*n+1];
          node_id_s[n]    = node_id_s[2*n+1];
        end else begin
          node_valid_s[n] = node_valid_s[2*n];
          node_prio_s[n]  = node_prio_s[2*n];
          node_id_s[n]    = node_id_s[2*n];
        end
      end
    end
    if (node_valid_s[0]) begin
      best_id_o       = node_id_s[0];
      best_priority_o = node_prio_s[0];
    end else begin
      best_id_o       = '0;
      best_priority_o = '0;
    end
  end

endmodule

// File: rtl/lagarto_plic_target_arbiter.sv
// Per-target PLIC core: latches gateway requests as pending, holds priority,
// enable and threshold, raises eip and hands out claims (highest priority,
// lowest ID on ties). A claimed source stays in flight, with its gateway
// frozen, until the hart completes it.
module lagarto_plic_target_arbiter
  import lagarto_plic_pkg::*;
#(
  parameter int NUM_SOURCES    = DEFAULT_NUM_SOURCES,
  parameter int PRIORITY_WIDTH = DEFAULT_PRIORITY_WIDTH,
  parameter int ID_WIDTH       = $clog2(NUM_SOURCES)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  lagarto_plic_target_arbiter_if.slave  bus
);
  localparam logic [ID_WIDTH:0]      SRC_LIMIT = (ID_WIDTH+1)'(NUM_SOURCES);
  localparam logic [NUM_SOURCES-1:0] ID0_MASK  = {{(NUM_SOURCES-1){1'b0}}, 1'b1};

  logic [NUM_SOURCES-1:0]                     pending_q, pending_d;
  logic [NUM_SOURCES-1:0]                     inflight_q, inflight_d;
  logic [NUM_SOURCES-1:0]                     enable_q, enable_d;
  logic [NUM_SOURCES-1:0][PRIORITY_WIDTH-1:0] priority_q, priority_d;
  logic [PRIORITY_WIDTH-1:0]                  threshold_q, threshold_d;
  logic [ID_WIDTH-1:0]                        claim_id_q, claim_id_d;
  logic                                       claim_valid_q, claim_valid_d;
  logic                                       eip_q, eip_d;

  logic [NUM_SOURCES-1:0]    idle_s;
  logic [NUM_SOURCES-1:0]    eligible_s;
  logic [ID_WIDTH-1:0]       best_id_s;
  logic [PRIORITY_WIDTH-1:0] best_priority_s;

  // Real source IDs are 1..NUM_SOURCES-1; ID 0 means "no interrupt".
  function automatic logic id_is_real(input logic [ID_WIDTH-1:0] id);
    return (id != '0) && ({1'b0, id} < SRC_LIMIT);
  endfunction

  // A source is idle when neither pending nor in flight; only idle sources
  // let their gateway through. ID 0 is reported permanently idle.
  always_comb begin
    idle_s = ~pending_q & ~inflight_q;
    bus.interrupt_claim_complete_o = idle_s | ID0_MASK;
  end

  // Eligibility: pending, enabled and strictly above the target threshold.
  always_comb begin
    eligible_s = '0;
    for (int k = 1; k < NUM_SOURCES; k++) begin
      eligible_s[k] = pending_q[k] & enable_q[k] & (priority_q[k] > threshold_q);
    end
  end

  lagarto_plic_max_tree #(
    .NUM_SOURCES    (NUM_SOURCES),
    .PRIORITY_WIDTH (PRIORITY_WIDTH),
    .ID_WIDTH       (ID_WIDTH)
  ) u_max_tree (
    .eligible_i      (eligible_s),
    .priority_i      (priority_q),
    .best_id_o       (best_id_s),
    .best_priority_o (best_priority_s)
  );

  // Next-state: gateway sampling, claim, complete and config writes. All
  // decisions use the current registered state, so a claim coinciding with
  // a config write sees the old configuration.
  always_comb begin
    pending_d     = pending_q | (bus.interrupt_request_i & idle_s & ~ID0_MASK);
    inflight_d    = inflight_q;
    enable_d      = enable_q;
    priority_d    = priority_q;
    threshold_d   = threshold_q;
    claim_id_d    = claim_id_q;
    claim_valid_d = bus.claim_req_i;
    eip_d         = (best_id_s != '0);

    if (bus.claim_req_i) begin
      claim_id_d = best_id_s;
      if (best_id_s != '0) begin
        pending_d[best_id_s]  = 1'b0;
        inflight_d[best_id_s] = 1'b1;
      end else begin
        // Nothing eligible: the claim reports ID 0 and leaves state alone.
      end
    end else begin
      // No claim this cycle; last claimed ID is held.
    end

    // The claimed source was pending, the completed one in flight, so the
    // two updates never touch the same bit.
    if (bus.complete_req_i && id_is_real(bus.complete_id_i) &&
        inflight_q[bus.complete_id_i]) begin
      inflight_d[bus.complete_id_i] = 1'b0;
    end else begin
      // Completes for non-inflight or invalid IDs are dropped.
    end

    if (bus.cfg_we_i) begin
      case (bus.cfg_sel_i)
        CFG_PRIORITY: begin
          if (id_is_real(bus.cfg_index_i)) begin
            priority_d[bus.cfg_index_i] = bus.cfg_wdata_i;
          end else begin
            // ID 0 and out-of-range indices have no priority register.
          end
        end
        CFG_ENABLE: begin
          if (id_is_real(bus.cfg_index_i)) begin
            enable_d[bus.cfg_index_i] = bus.cfg_wdata_i[0];
          end else begin
            // ID 0 and out-of-range indices have no enable bit.
          end
        end
        CFG_THRESHOLD: threshold_d = bus.cfg_wdata_i;
        default: begin
          // Reserved select: write dropped.
        end
      endcase
    end else begin
      // No configuration write.
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q     <= '0;
      inflight_q    <= '0;
      enable_q      <= '0;
      priority_q    <= '0;
      threshold_q   <= '0;
      claim_id_q    <= '0;
      claim_valid_q <= 1'b0;
      eip_q         <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      inflight_q    <= inflight_d;
      enable_q      <= enable_d;
      priority_q    <= priority_d;
      threshold_q   <= threshold_d;
      claim_id_q    <= claim_id_d;
      claim_valid_q <= claim_valid_d;
      eip_q         <= eip_d;
    end
  end

  assign bus.claim_valid_o = claim_valid_q;
  assign bus.claim_id_o    = claim_id_q;
  assign bus.eip_o         = eip_q;

endmodule

// File: tb/tb_lagarto_plic_target_arbiter.sv
// Self-checking bench for lagarto_plic_target_arbiter: a table of per-cycle
// vectors with expected eip/claim_complete, claim IDs queued on a scoreboard
// and checked when claim_valid_o pulses, plus a hand-written async reset case.
module tb_lagarto_plic_target_arbiter;
  import lagarto_plic_pkg::*;

  logic clk   = 1'b0;
  logic rst_i = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [4:0] sb[$];
  logic [4:0] sb_exp;

  typedef struct {
    string       name;
    logic [31:0] req;
    logic        we;
    logic [1:0]  sel;
    logic [4:0]  idx;
    logic [2:0]  wd;
    logic        cl;
    logic        cp;
    logic [4:0]  cid;
    logic        ce;    // compare eip after this cycle
    logic        ee;    // expected eip
    logic [31:0] busy;  // expected pending|inflight mask after the edge
    logic [4:0]  eid;   // expected claim ID when cl is set
  } vec_t;

  vec_t vecs[$];
  vec_t post[$];

  lagarto_plic_target_arbiter_if #(
    .NUM_SOURCES(32), .PRIORITY_WIDTH(3), .ID_WIDTH(5)
  ) bus ();

  lagarto_plic_target_arbiter #(
    .NUM_SOURCES(32), .PRIORITY_WIDTH(3), .ID_WIDTH(5)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic logic [31:0] m(input int k);
    return 32'h1 << k;
  endfunction

  function automatic vec_t V(input string n, input logic [31:0] req, input logic we,
                             input logic [1:0] sel, input logic [4:0] idx, input logic [2:0] wd,
                             input logic cl, input logic cp, input logic [4:0] cid,
                             input logic ce, input logic ee, input logic [31:0] busy,
                             input logic [4:0] eid);
    vec_t v;
    v.name = n; v.req = req; v.we = we; v.sel = sel; v.idx = idx; v.wd = wd;
    v.cl = cl; v.cp = cp; v.cid = cid; v.ce = ce; v.ee = ee; v.busy = busy; v.eid = eid;
    return v;
  endfunction

  // Config write cycle with no other activity; eip expected low.
  function automatic vec_t W(input string n, input logic [1:0] sel, input logic [4:0] idx,
                             input logic [2:0] wd, input logic [31:0] busy);
    return V(n, 32'h0, 1'b1, sel, idx, wd, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, busy, 5'd0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.interrupt_request_i = '0;
    bus.cfg_we_i = 1'b0; bus.cfg_sel_i = 2'd0; bus.cfg_index_i = 5'd0; bus.cfg_wdata_i = 3'd0;
    bus.claim_req_i = 1'b0; bus.complete_req_i = 1'b0; bus.complete_id_i = 5'd0;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    bus.interrupt_request_i = v.req;
    bus.cfg_we_i = v.we; bus.cfg_sel_i = v.sel; bus.cfg_index_i = v.idx; bus.cfg_wdata_i = v.wd;
    bus.claim_req_i = v.cl; bus.complete_req_i = v.cp; bus.complete_id_i = v.cid;
    if (v.cl) sb.push_back(v.eid);
    @(posedge clk);
    #1;
    check({v.name, ":claim_complete"}, bus.interrupt_claim_complete_o, ~v.busy);
    if (v.ce) check({v.name, ":eip"}, {31'b0, bus.eip_o}, {31'b0, v.ee});
  endtask

  // Scoreboard consumer and pending/inflight exclusivity watch.
  always @(negedge clk) begin
    if (!rst_i) begin
      check("pending_and_inflight", dut.pending_q & dut.inflight_q, 32'h0);
      if (bus.claim_valid_o) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL claim_unexpected: got claim id %0d, expected no claim", bus.claim_id_o);
        end else begin
          sb_exp = sb.pop_front();
          check("claim_id", {27'b0, bus.claim_id_o}, {27'b0, sb_exp});
        end
      end
    end
  end

  // Run-time bound.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Main sequence.
  initial begin
    logic [31:0] m379;
    drive_idle();
    #1 rst_i = 1'b1;
    #1;
    check("reset:eip", {31'b0, bus.eip_o}, 32'h0);
    check("reset:claim_valid", {31'b0, bus.claim_valid_o}, 32'h0);
    check("reset:claim_id", {27'b0, bus.claim_id_o}, 32'h0);
    check("reset:claim_complete", bus.interrupt_claim_complete_o, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    m379 = m(3) | m(7) | m(9);
    // Single source, request -> pending -> eip -> claim -> complete
    vecs.push_back(W("p5", CFG_PRIORITY, 5'd5, 3'd3, 32'h0));
    vecs.push_back(W("e5", CFG_ENABLE, 5'd5, 3'd1, 32'h0));
    vecs.push_back(V("rq5", m(5), 0, 0, 0, 0, 0, 0, 0, 1, 0, m(5), 0));
    vecs.push_back(V("eip5", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, m(5), 0));
    vecs.push_back(V("cl5", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, m(5), 5));
    vecs.push_back(V("cp5", 0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 32'h0, 0));
    // Priority order and lowest-ID tie break, back-to-back claims
    vecs.push_back(W("p3", CFG_PRIORITY, 5'd3, 3'd2, 32'h0));
    vecs.push_back(W("p7", CFG_PRIORITY, 5'd7, 3'd2, 32'h0));
    vecs.push_back(W("p9", CFG_PRIORITY, 5'd9, 3'd4, 32'h0));
    vecs.push_back(W("e3", CFG_ENABLE, 5'd3, 3'd1, 32'h0));
    vecs.push_back(W("e7", CFG_ENABLE, 5'd7, 3'd1, 32'h0));
    vecs.push_back(W("e9", CFG_ENABLE, 5'd9, 3'd1, 32'h0));
    vecs.push_back(V("rq379", m379, 0, 0, 0, 0, 0, 0, 0, 1, 0, m379, 0));
    vecs.push_back(V("cl9", 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, m379, 9));
    vecs.push_back(V("cl3", 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, m379, 3));
    vecs.push_back(V("cl7", 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, m379, 7));
    vecs.push_back(V("cl0", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, m379, 0));
    vecs.push_back(V("cp9", 0, 0, 0, 0, 0, 0, 1, 9, 1, 0, m(3) | m(7), 0));
    vecs.push_back(V("cp3", 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, m(7), 0));
    vecs.push_back(V("cp7", 0, 0, 0, 0, 0, 0, 1, 7, 1, 0, 32'h0, 0));
    // Threshold equal to priority blocks; lowering it releases
    vecs.push_back(W("p2", CFG_PRIORITY, 5'd2, 3'd4, 32'h0));
    vecs.push_back(W("e2", CFG_ENABLE, 5'd2, 3'd1, 32'h0));
    vecs.push_back(W("thr4", CFG_THRESHOLD, 5'd0, 3'd4, 32'h0));
    vecs.push_back(V("rq2", m(2), 0, 0, 0, 0, 0, 0, 0, 1, 0, m(2), 0));
    vecs.push_back(V("thr_blk", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, m(2), 0));
    vecs.push_back(V("cl_thr", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, m(2), 0));
    vecs.push_back(W("thr3", CFG_THRESHOLD, 5'd0, 3'd3, m(2)));
    vecs.push_back(V("eip_thr", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, m(2), 0));
    vecs.push_back(V("cl2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, m(2), 2));
    vecs.push_back(V("cp2", 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 32'h0, 0));
    vecs.push_back(W("thr0", CFG_THRESHOLD, 5'd0, 3'd0, 32'h0));
    // Held request, wrong/zero completes ignored, re-pend after completion
    vecs.push_back(V("h5a", m(5), 0, 0, 0, 0, 0, 0, 0, 1, 0, m(5), 0));
    vecs.push_back(V("h5cl", m(5), 0, 0, 0, 0, 1, 0, 0, 0, 0, m(5), 5));
    vecs.push_back(V("h5cp6", m(5), 0, 0, 0, 0, 0, 1, 6, 1, 0, m(5), 0));
    vecs.push_back(V("h5cp0", m(5), 0, 0, 0, 0, 0, 1, 0, 1, 0, m(5), 0));
    vecs.push_back(V("h5cp5", m(5), 0, 0, 0, 0, 0, 1, 5, 1, 0, 32'h0, 0));
    vecs.push_back(V("h5re", m(5), 0, 0, 0, 0, 0, 0, 0, 1, 0, m(5), 0));
    vecs.push_back(V("h5cl2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, m(5), 5));
    vecs.push_back(V("h5cp", 0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 32'h0, 0));
    // Claim and complete in the same cycle
    vecs.push_back(W("p4", CFG_PRIORITY, 5'd4, 3'd5, 32'h0));
    vecs.push_back(W("e4", CFG_ENABLE, 5'd4, 3'd1, 32'h0));
    vecs.push_back(W("p8", CFG_PRIORITY, 5'd8, 3'd1, 32'h0));
    vecs.push_back(W("e8", CFG_ENABLE, 5'd8, 3'd1, 32'h0));
    vecs.push_back(V("rq4", m(4), 0, 0, 0, 0, 0, 0, 0, 1, 0, m(4), 0));
    vecs.push_back(V("cl4", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, m(4), 4));
    vecs.push_back(V("rq8", m(8), 0, 0, 0, 0, 0, 0, 0, 1, 0, m(4) | m(8), 0));
    vecs.push_back(V("clcp", 0, 0, 0, 0, 0, 1, 1, 4, 0, 0, m(8), 8));
    vecs.push_back(V("cp8", 0, 0, 0, 0, 0, 0, 1, 8, 1, 0, 32'h0, 0));
    // Disabled source stays pending; claim with concurrent enable uses old value
    vecs.push_back(W("p10", CFG_PRIORITY, 5'd10, 3'd6, 32'h0));
    vecs.push_back(V("rq10", m(10), 0, 0, 0, 0, 0, 0, 0, 1, 0, m(10), 0));
    vecs.push_back(V("dis10", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, m(10), 0));
    vecs.push_back(V("cl_en10", 0, 1, CFG_ENABLE, 10, 1, 1, 0, 0, 1, 0, m(10), 0));
    vecs.push_back(V("en_eip", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, m(10), 0));
    vecs.push_back(V("cl10", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, m(10), 10));
    vecs.push_back(V("cp10", 0, 0, 0, 0, 0, 0, 1, 10, 1, 0, 32'h0, 0));
    // Load state ahead of the asynchronous reset
    vecs.push_back(V("rq379b", m379, 0, 0, 0, 0, 0, 0, 0, 1, 0, m379, 0));
    vecs.push_back(V("cl9b", 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, m379, 9));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Asynchronous reset between edges with a claim strobe raised
    @(negedge clk);
    drive_idle();
    bus.claim_req_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    check("async_rst:eip", {31'b0, bus.eip_o}, 32'h0);
    check("async_rst:claim_valid", {31'b0, bus.claim_valid_o}, 32'h0);
    check("async_rst:claim_id", {27'b0, bus.claim_id_o}, 32'h0);
    check("async_rst:claim_complete", bus.interrupt_claim_complete_o, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("rst_hold:claim_valid", {31'b0, bus.claim_valid_o}, 32'h0);
    check("rst_hold:claim_complete", bus.interrupt_claim_complete_o, 32'hFFFF_FFFF);
    @(negedge clk);
    bus.claim_req_i = 1'b0;
    rst_i = 1'b0;

    // Configuration was cleared: request pends but priority 0 never fires
    post.push_back(V("post_rq5", m(5), 0, 0, 0, 0, 0, 0, 0, 1, 0, m(5), 0));
    post.push_back(V("post_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, m(5), 0));
    post.push_back(V("post_cl", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, m(5), 0));
    for (int i = 0; i < post.size(); i++) apply(post[i]);

    @(negedge clk);
    drive_idle();
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
